// File: rtl/hack_cpu_ctrl_pkg.sv
// Shared Hack CPU control definitions: state encodings, instruction field positions, reset PC.
// Purely declarative; no logic, no latency.
// Imported by the control stage, the jump unit and the testbench.
package hack_cpu_ctrl_pkg;

  // Two-state multi-cycle sequencer: fetch an instruction, then execute it.
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  // Instruction word bit positions.
  localparam int IS_C    = 15;
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JMP_LT  = 2;
  localparam int JMP_EQ  = 1;
  localparam int JMP_GT  = 0;

  localparam logic [14:0] RESET_PC_DEFAULT = 15'h0000;

  // Extract the three jump bits (j1 j2 j3) of an instruction.
  function automatic logic [2:0] jump_bits(input logic [15:0] instr);
    return {instr[JMP_LT], instr[JMP_EQ], instr[JMP_GT]};
  endfunction

endpackage

// File: rtl/hack_cpu_ctrl_jump_unit.sv
// Hack jump condition: decides whether a C-instruction jump is taken from j1..j3 and the ALU flags.
// Purely combinational, zero latency.
// No handshake; the caller gates the result by instruction type and state.
module hack_jump_unit (
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  // j[2]=less-than, j[1]=equal, j[0]=greater-than, all relative to zero.
  always_comb begin
    take = (j[2] & ng) | (j[1] & zr) | (j[0] & ~zr & ~ng);
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control stage: owns PC/A/D/IR, drives the external ALU, issues memory writes and jumps.
// Two cycles per instruction minimum (FETCH, EXEC); fetch stalls in FETCH until the instruction ack arrives.
// Instruction-side backpressure is the ack; data writes are a single-cycle strobe with no stall.
module hack_cpu_ctrl
  import hack_cpu_ctrl_pkg::*;
#(
  parameter int          WIDTH    = 16,
  parameter logic [14:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  output logic [14:0]      o_IMemAddr,
  output logic             o_IMemReq,
  input  logic             i_IMemAck,
  input  logic [WIDTH-1:0] i_Instr,
  output logic [14:0]      o_DMemAddr,
  input  logic [WIDTH-1:0] i_DMemData,
  output logic [WIDTH-1:0] o_DMemData,
  output logic             o_DMemWrite,
  output logic [WIDTH-1:0] o_X,
  output logic [WIDTH-1:0] o_Y,
  output logic             o_ZX,
  output logic             o_NX,
  output logic             o_ZY,
  output logic             o_NY,
  output logic             o_F,
  output logic             o_NO,
  input  logic [WIDTH-1:0] i_ALU,
  input  logic             i_ZR,
  input  logic             i_NG
);

  state_t           state;
  state_t           state_nxt;
  logic [14:0]      pc;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] ir;

  logic             exec_c;
  logic             exec_a;
  logic             jump_raw;
  logic [5:0]       comp;

  // Jump condition is evaluated on the live ALU flags of the current EXEC cycle.
  hack_jump_unit u_jump (
    .j    (jump_bits(ir)),
    .zr   (i_ZR),
    .ng   (i_NG),
    .take (jump_raw)
  );

  assign comp = ir[COMP_HI:COMP_LO];

  // State register; reset forces FETCH immediately, which also kills any write strobe in flight.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and decoded outputs; everything is driven from state so reset takes effect at once.
  always_comb begin
    state_nxt   = state;
    o_IMemReq   = 1'b0;
    exec_c      = 1'b0;
    exec_a      = 1'b0;
    o_DMemWrite = 1'b0;
    {o_ZX, o_NX, o_ZY, o_NY, o_F, o_NO} = 6'b000000;
    case (state)
      FETCH: begin
        o_IMemReq = 1'b1;
        if (i_IMemAck) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = FETCH;
        if (ir[IS_C]) begin
          exec_c      = 1'b1;
          o_DMemWrite = ir[DEST_M];
          {o_ZX, o_NX, o_ZY, o_NY, o_F, o_NO} = comp;
        end else begin
          exec_a = 1'b1;
        end
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // Architectural registers: IR captured on fetch ack, PC/A/D updated at the end of EXEC.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      pc    <= RESET_PC;
      a_reg <= '0;
      d_reg <= '0;
      ir    <= '0;
    end else begin
      if (o_IMemReq && i_IMemAck) begin
        ir <= i_Instr;
      end
      if (exec_a) begin
        a_reg <= {1'b0, ir[14:0]};
        pc    <= pc + 15'd1;
      end
      if (exec_c) begin
        if (ir[DEST_A]) begin
          a_reg <= i_ALU;
        end
        if (ir[DEST_D]) begin
          d_reg <= i_ALU;
        end
        // Jump target is the pre-update A, even when A is also a destination.
        pc <= jump_raw ? a_reg[14:0] : pc + 15'd1;
      end
    end
  end

  assign o_IMemAddr = pc;
  assign o_DMemAddr = a_reg[14:0];
  assign o_DMemData = i_ALU;
  assign o_X        = d_reg;
  assign o_Y        = ir[A_BIT] ? i_DMemData : a_reg;

endmodule
